// File: rtl/sort_pkg.sv
// Shared types and helpers for the sort result checker: FSM encoding,
// median index selection and sum width sizing.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_e;

  // Odd frames take the true middle element, even frames the lower middle.
  function automatic int median_idx(input int n);
    return (n % 2 == 1) ? n / 2 : n / 2 - 1;
  endfunction

  function automatic int sum_width(input int n, input int bw);
    return bw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sort_result_checker_if.sv
// Stream input and result handshake bundle between the sorter, the checker
// and whoever consumes the report.
interface sort_result_checker_if #(
  parameter int bitwidth = 8,
  parameter int SUMW     = 12
);
  logic                in_valid;
  logic [bitwidth-1:0] in_data;
  logic                in_done;
  logic                res_valid;
  logic                res_ack;
  logic [bitwidth-1:0] min_val;
  logic [bitwidth-1:0] max_val;
  logic [bitwidth-1:0] median;
  logic [SUMW-1:0]     sum;
  logic                sorted_ok;
  logic                count_err;
  logic                busy;

  modport master (
    output in_valid, in_data, in_done, res_ack,
    input  res_valid, min_val, max_val, median, sum, sorted_ok, count_err, busy
  );

  modport slave (
    input  in_valid, in_data, in_done, res_ack,
    output res_valid, min_val, max_val, median, sum, sorted_ok, count_err, busy
  );
endinterface

// File: rtl/stream_stats.sv
// Running min/max/sum and non-decreasing order check over a value stream.
// clear+update together start a new frame from the incoming value.
module stream_stats #(
  parameter int bitwidth = 8,
  parameter int SUMW     = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                update,
  input  logic [bitwidth-1:0] din,
  output logic [bitwidth-1:0] min_val,
  output logic [bitwidth-1:0] max_val,
  output logic [SUMW-1:0]     sum,
  output logic                sorted_ok
);

  logic [bitwidth-1:0] min_q, min_d;
  logic [bitwidth-1:0] max_q, max_d;
  logic [bitwidth-1:0] last_q, last_d;
  logic [SUMW-1:0]     sum_q, sum_d;
  logic                sorted_q, sorted_d;

  always_comb begin
    min_d    = min_q;
    max_d    = max_q;
    last_d   = last_q;
    sum_d    = sum_q;
    sorted_d = sorted_q;
    if (clear && update) begin
      min_d    = din;
      max_d    = din;
      last_d   = din;
      sum_d    = SUMW'(din);
      sorted_d = 1'b1;
    end else if (clear) begin
      min_d    = '0;
      max_d    = '0;
      last_d   = '0;
      sum_d    = '0;
      sorted_d = 1'b0;
    end else if (update) begin
      if (din < min_q) min_d = din;
      if (din > max_q) max_d = din;
      // Equal neighbours are allowed; only a strict drop breaks the order.
      if (din < last_q) sorted_d = 1'b0;
      last_d = din;
      sum_d  = sum_q + SUMW'(din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q    <= '0;
      max_q    <= '0;
      last_q   <= '0;
      sum_q    <= '0;
      sorted_q <= 1'b0;
    end else begin
      min_q    <= min_d;
      max_q    <= max_d;
      last_q   <= last_d;
      sum_q    <= sum_d;
      sorted_q <= sorted_d;
    end
  end

  assign min_val   = min_q;
  assign max_val   = max_q;
  assign sum       = sum_q;
  assign sorted_ok = sorted_q;

endmodule

// File: rtl/sort_result_checker.sv
// Captures one sorted frame from the SHOW stream, checks order and length,
// and reports min/max/median/sum through a valid/ack handshake.
module sort_result_checker
  import sort_pkg::*;
#(
  parameter int N        = 5,
  parameter int bitwidth = 8,
  parameter int SUMW     = sum_width(N, bitwidth)
) (
  input  logic                 clk,
  input  logic                 rst,
  sort_result_checker_if.slave bus
);

  localparam int              CNTW    = $clog2(N + 1);
  localparam int              MED_IDX = median_idx(N);
  localparam logic [CNTW-1:0] N_CNT   = CNTW'(N);
  localparam logic [CNTW-1:0] MED_CNT = CNTW'(MED_IDX);

  state_e              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                pend_q, pend_d;
  logic                res_valid_q, res_valid_d;
  logic                busy_q, busy_d;
  logic                count_err_q, count_err_d;
  logic [bitwidth-1:0] median_q, median_d;
  logic [bitwidth-1:0] mem_q [N];
  logic [bitwidth-1:0] mem_d [N];

  logic                wr_en;
  logic [CNTW-1:0]     wr_idx;
  logic                st_clear;
  logic                st_update;
  logic [bitwidth-1:0] st_min;
  logic [bitwidth-1:0] st_max;
  logic [SUMW-1:0]     st_sum;
  logic                st_sorted;

  stream_stats #(
    .bitwidth (bitwidth),
    .SUMW     (SUMW)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .clear     (st_clear),
    .update    (st_update),
    .din       (bus.in_data),
    .min_val   (st_min),
    .max_val   (st_max),
    .sum       (st_sum),
    .sorted_ok (st_sorted)
  );

  // REPORT spends one cycle (pend) latching the report before raising res_valid.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    pend_d      = pend_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    count_err_d = count_err_q;
    median_d    = median_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    st_clear    = 1'b0;
    st_update   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          wr_en       = 1'b1;
          st_clear    = 1'b1;
          st_update   = 1'b1;
          cnt_d       = CNTW'(1);
          ovf_d       = 1'b0;
          busy_d      = 1'b1;
          count_err_d = 1'b0;
          median_d    = '0;
          state_d     = COLLECT;
          if (bus.in_done) begin
            state_d = REPORT;
            pend_d  = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          if (cnt_q < N_CNT) begin
            wr_en     = 1'b1;
            wr_idx    = cnt_q;
            st_update = 1'b1;
            cnt_d     = cnt_q + CNTW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (bus.in_done) begin
          state_d = REPORT;
          pend_d  = 1'b1;
        end
      end
      REPORT: begin
        if (pend_q) begin
          pend_d      = 1'b0;
          res_valid_d = 1'b1;
          busy_d      = 1'b0;
          count_err_d = (cnt_q != N_CNT) || ovf_q;
          median_d    = (MED_CNT < cnt_q) ? mem_q[MED_IDX] : '0;
        end else if (res_valid_q && bus.res_ack) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < N; i++) begin
      if (wr_en && (wr_idx == CNTW'(i))) mem_d[i] = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      count_err_q <= 1'b0;
      median_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      pend_q      <= pend_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      count_err_q <= count_err_d;
      median_q    <= median_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;
  assign bus.count_err = count_err_q;
  assign bus.median    = median_q;
  assign bus.min_val   = st_min;
  assign bus.max_val   = st_max;
  assign bus.sum       = st_sum;
  assign bus.sorted_ok = st_sorted;

endmodule

// File: doc/sort_result_checker.md
Name: sort_result_checker

Overview:
- Downstream stage of the selection-sort datapath. It consumes the serial SHOW stream (one value per strobe, then a done pulse) and captures up to N values.
- It checks that the stream is in non-decreasing order and that exactly N values arrived.
- It reports min, max, median and sum through a valid/ack result handshake, to the board display or to the bench scoreboard.

Parameters:
- N, 5, number of values per sorted frame (1..15).
- bitwidth, 8, width of each value.
- SUMW, bitwidth+$clog2(N)+1, width of the sum output; never overflows for N values.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  one value present on in_data this cycle.
- in_data  in  bitwidth  value from the sorter's val_out.
- in_done  in  1  end of frame; driven from the sorter's end_show, sampled as a level.
- res_valid  out  1  result outputs are stable and valid.
- res_ack  in  1  consumer accepts the result.
- min_val  out  bitwidth  smallest captured value.
- max_val  out  bitwidth  largest captured value.
- median  out  bitwidth  element at index N/2 for odd N, N/2-1 for even N.
- sum  out  SUMW  sum of captured values.
- sorted_ok  out  1  every value was >= its predecessor.
- count_err  out  1  frame length was not N (short or overflow).
- busy  out  1  a frame is being collected.

Behaviour:
- Reset: on rst=1 at a clock edge, all outputs, the counter, the internal buffer pointer and the state go to 0 (IDLE). This applies mid-frame and mid-report; any partial frame is discarded.
- States: IDLE, COLLECT, REPORT. The state is 2 bits.
- IDLE:
  - in_valid=1: capture in_data as element 0, cnt<=1, go to COLLECT, busy<=1.
  - in_done=1 with in_valid=0: ignored.
- COLLECT:
  - Each in_valid with cnt<N: store in_data at index cnt and increment cnt.
  - sorted_ok is cleared if in_data < previous value. Equal values keep it set.
  - min and max are tracked incrementally; sum accumulates.
  - in_valid with cnt==N: the value is dropped, an overflow flag is set, and cnt saturates at N.
  - in_done=1: go to REPORT.
  - in_valid and in_done in the same cycle: the value is captured first, then the block finishes.
- REPORT entry (the cycle after in_done is sampled):
  - res_valid<=1 and busy<=0.
  - count_err<=(final cnt!=N) or overflow.
  - median is taken from buffer index N/2 (odd N) or N/2-1 (even N). If cnt is short and the median index is >= cnt, median<=0.
  - Latency: in_done at edge k gives res_valid high after edge k+1.
- REPORT hold:
  - Outputs hold until res_ack=1, sampled while res_valid=1.
  - On that edge: res_valid<=0 and go to IDLE. Result outputs keep their values until the next frame's first capture.
  - in_valid and in_done are ignored in REPORT; values are not queued.
- Arithmetic: unsigned compares; the sum is zero-extended to SUMW. Initial min/max/sum come from the first value, not from 0.
- Buffer: N x bitwidth register array, written only in COLLECT/IDLE, read only at REPORT entry.
- First value of a frame: no order check.
- N=1: median = the single value; sorted_ok=1.

Decomposition:
- Shared package sort_pkg:
  - state encoding constants (IDLE=0, COLLECT=1, REPORT=2);
  - function for the median index;
  - SUMW helper.
- Sub-module stream_stats: the running min/max/sum/order-check accumulator, with clear and update inputs.
  - The top level holds the FSM, the buffer, the counter and the handshake.

Test Plan:
- Nominal frame: stream 3,7,7,12,40 then in_done → next cycle res_valid=1, min=3, max=40, median=7, sum=69, sorted_ok=1, count_err=0. Ack → res_valid=0, state IDLE.
- Unsorted frame: stream 5,2,9,9,1 → sorted_ok=0, min=1, max=9, median=9, sum=26, count_err=0.
- Short and long frames:
  - 4 values 10,20,30,40 then in_done → count_err=1, median=30, sum=100.
  - 6 values, with the 6th=255 → sixth value dropped, count_err=1, max unaffected.
- Boundary values:
  - All 255 → sum=1275 exactly, min=max=median=255.
  - All 0 → sum=0, sorted_ok=1.
- Handshake and overlap:
  - in_valid with the last value in the same cycle as in_done → the value is counted.
  - in_valid during REPORT without ack → ignored; outputs stable for 10 cycles until ack.
- Reset mid-COLLECT after 2 values → all outputs 0. A following full frame 1,2,3,4,5 reports sum=15, median=3.
